tinyqv_data_arbiter: RTL and testbench
======================================

TINYQV_DATA_ARBITER -- requirements
Module: tinyqv_data_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports a_addr in 28, a_write_n in 2, a_read_n in 2, a_wdata in 32: requester A (CPU). Size code: 11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit.
REQ-004 SHALL have ports a_ready out 1 and a_rdata out 32: A completion pulse and read data.
REQ-005 SHALL have ports b_addr, b_write_n, b_read_n, b_wdata, b_ready, b_rdata: requester B (DMA), with the same widths and meanings as A.
REQ-006 SHALL have ports data_addr out 28, data_write_n out 2, data_read_n out 2, data_out out 32: shared peripheral bus.
REQ-007 SHALL have ports data_ready in 1 and data_in in 32: peripheral completion and read data.
REQ-008 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.
REQ-009 SHALL have port err_clear, input, 1 bit: clears timeout_err.
REQ-010 SHALL have parameter TIMEOUT, default 255: maximum number of BUSY cycles before abort.

Function
REQ-011 SHALL treat a requester as requesting when its write_n != 11 or its read_n != 11; if both are non-11, write SHALL take precedence and read_n SHALL be forwarded as 11.
REQ-012 SHALL hold requests stable until the matching x_ready pulse; the arbiter SHALL NOT check for changes.
REQ-013 SHALL implement the states IDLE, BUSY and DONE.
REQ-014 IDLE, exactly one requester: SHALL grant it, register its addr/write_n/read_n/wdata onto the data_* outputs, and enter BUSY at the next edge.
REQ-015 IDLE, both requesting: SHALL grant the requester that was not granted last (round-robin pointer); after reset the pointer SHALL favour A.
REQ-016 BUSY: data_* outputs SHALL stay constant.
REQ-017 BUSY with data_ready=1: SHALL capture data_in into the granted x_rdata, drive data_write_n and data_read_n to 11, and enter DONE.
REQ-018 DONE: SHALL assert the granted x_ready for exactly one cycle, toggle the pointer, and return to IDLE; no new grant is made in DONE.
REQ-019 Latency: request in cycle N gives bus driven in N+1; data_ready in cycle M gives x_ready in M+1; minimum spacing between back-to-back grants is 3 cycles.
REQ-020 On a write, x_rdata SHALL be left unchanged.
REQ-021 The non-granted requester's x_ready SHALL stay 0 and its x_rdata SHALL stay unchanged.
REQ-022 SHALL keep a BUSY cycle counter cleared on entry to BUSY; when the count reaches TIMEOUT with data_ready=0, SHALL abort: drive bus size codes to 11, set x_rdata=FFFFFFFF, set timeout_err, and enter DONE.
REQ-023 If data_ready=1 in the same cycle as timeout expiry, data_ready SHALL win and timeout_err SHALL NOT be set.
REQ-024 err_clear SHALL clear timeout_err at the next edge; if it coincides with a new timeout event, the set SHALL win.
REQ-025 data_ready while in IDLE or DONE SHALL be ignored.

Reset
REQ-026 With rst=1 at an edge: state=IDLE, pointer=A, counter=0, data_addr=0, data_write_n=11, data_read_n=11, data_out=0, a_ready=b_ready=0, a_rdata=b_rdata=0, timeout_err=0.
REQ-027 Reset mid-BUSY or mid-DONE SHALL abandon the transaction with no x_ready pulse; requests still asserted after reset SHALL be re-arbitrated from IDLE.

Verification
REQ-028 Single read: A reads 32-bit at 0x8000010, data_ready in the 3rd BUSY cycle with data_in=0x12345678 -> a_rdata=0x12345678 and a_ready high for 1 cycle; b_ready stays 0.
REQ-029 Contention: A and B request together after reset -> A granted first; B granted in the cycle after A's DONE; then both request again -> B's turn is consumed, so A is granted next.
REQ-030 Write: B writes 8-bit (write_n=00), wdata=0xAB -> data_write_n=00 and data_out=0xAB for the whole of BUSY; b_rdata unchanged.
REQ-031 Timeout: data_ready never asserted -> abort after 255 BUSY cycles: x_rdata=FFFFFFFF, x_ready pulses once, timeout_err=1 until err_clear.
REQ-032 Edge cases: data_ready in the expiry cycle -> normal completion with timeout_err=0; rst pulsed mid-BUSY -> outputs return to reset values with no ready pulse.

Source files
------------

// File: rtl/tinyqv_data_arbiter_if.sv
// rtl/tinyqv_data_arbiter_if.sv - requester A/B and shared peripheral bus bundle for the data arbiter
interface tinyqv_data_arbiter_if;
    logic [27:0] a_addr;
    logic [1:0]  a_write_n;
    logic [1:0]  a_read_n;
    logic [31:0] a_wdata;
    logic        a_ready;
    logic [31:0] a_rdata;

    logic [27:0] b_addr;
    logic [1:0]  b_write_n;
    logic [1:0]  b_read_n;
    logic [31:0] b_wdata;
    logic        b_ready;
    logic [31:0] b_rdata;

    logic [27:0] data_addr;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic [31:0] data_in;

    // Arbiter side: serves both requesters and drives the peripheral bus.
    modport master (
        input  a_addr, a_write_n, a_read_n, a_wdata,
        output a_ready, a_rdata,
        input  b_addr, b_write_n, b_read_n, b_wdata,
        output b_ready, b_rdata,
        output data_addr, data_write_n, data_read_n, data_out,
        input  data_ready, data_in
    );

    modport slave (
        output a_addr, a_write_n, a_read_n, a_wdata,
        input  a_ready, a_rdata,
        output b_addr, b_write_n, b_read_n, b_wdata,
        input  b_ready, b_rdata,
        input  data_addr, data_write_n, data_read_n, data_out,
        output data_ready, data_in
    );
endinterface

// File: rtl/tinyqv_data_arbiter.sv
// rtl/tinyqv_data_arbiter.sv - round-robin CPU/DMA arbiter onto one peripheral bus with BUSY timeout
module tinyqv_data_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    tinyqv_data_arbiter_if.master       bus,
    output logic                        timeout_err,
    input  logic                        err_clear
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [27:0]     addr_q, addr_d;
    logic [1:0]      wn_q, wn_d;
    logic [1:0]      rn_q, rn_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [31:0]     a_rdata_q, a_rdata_d;
    logic [31:0]     b_rdata_q, b_rdata_d;
    logic            a_ready_q, a_ready_d;
    logic            b_ready_q, b_ready_d;
    logic            terr_q, terr_d;

    logic            a_req, b_req, pick_b, expire, set_err;
    logic [27:0]     sel_addr;
    logic [1:0]      sel_wn;
    logic [1:0]      sel_rn;
    logic [31:0]     sel_wdata;

    assign a_req  = (bus.a_write_n != 2'b11) || (bus.a_read_n != 2'b11);
    assign b_req  = (bus.b_write_n != 2'b11) || (bus.b_read_n != 2'b11);
    assign pick_b = b_req && (!a_req || ptr_q);

    assign sel_addr  = pick_b ? bus.b_addr    : bus.a_addr;
    assign sel_wn    = pick_b ? bus.b_write_n : bus.a_write_n;
    assign sel_rn    = pick_b ? bus.b_read_n  : bus.a_read_n;
    assign sel_wdata = pick_b ? bus.b_wdata   : bus.a_wdata;

    // Expiry lands in the TIMEOUT-th BUSY cycle (counter starts at 0 on entry).
    assign expire = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            wn_q      <= 2'b11;
            rn_q      <= 2'b11;
            wdat_q    <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wn_q      <= wn_d;
            rn_q      <= rn_d;
            wdat_q    <= wdat_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            a_ready_q <= a_ready_d;
            b_ready_q <= b_ready_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (a_req || b_req) state_d = S_BUSY;
            S_BUSY:  if (bus.data_ready || expire) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wn_d      = wn_q;
        rn_d      = rn_q;
        wdat_d    = wdat_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        a_ready_d = 1'b0;
        b_ready_d = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (a_req || b_req) begin
                    gnt_d  = pick_b;
                    cnt_d  = '0;
                    addr_d = sel_addr;
                    wn_d   = sel_wn;
                    rn_d   = (sel_wn != 2'b11) ? 2'b11 : sel_rn;
                    wdat_d = sel_wdata;
                end
            end
            S_BUSY: begin
                if (bus.data_ready) begin
                    wn_d = 2'b11;
                    rn_d = 2'b11;
                    // rn_q is only non-11 for a granted read; writes leave rdata alone.
                    if (rn_q != 2'b11) begin
                        if (gnt_q) b_rdata_d = bus.data_in;
                        else       a_rdata_d = bus.data_in;
                    end
                    a_ready_d = !gnt_q;
                    b_ready_d = gnt_q;
                end else if (expire) begin
                    wn_d    = 2'b11;
                    rn_d    = 2'b11;
                    set_err = 1'b1;
                    if (gnt_q) b_rdata_d = 32'hFFFF_FFFF;
                    else       a_rdata_d = 32'hFFFF_FFFF;
                    a_ready_d = !gnt_q;
                    b_ready_d = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d = !gnt_q;
            end
            default: ;
        endcase
        terr_d = set_err || (terr_q && !err_clear);
    end

    assign bus.data_addr    = addr_q;
    assign bus.data_write_n = wn_q;
    assign bus.data_read_n  = rn_q;
    assign bus.data_out     = wdat_q;
    assign bus.a_ready      = a_ready_q;
    assign bus.b_ready      = b_ready_q;
    assign bus.a_rdata      = a_rdata_q;
    assign bus.b_rdata      = b_rdata_q;
    assign timeout_err      = terr_q;
endmodule

// File: tb/tb_tinyqv_data_arbiter.sv
// tb/tb_tinyqv_data_arbiter.sv - scoreboard bench for tinyqv_data_arbiter
module tb_tinyqv_data_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic err_clear;
    logic timeout_err;

    tinyqv_data_arbiter_if bus_if();

    tinyqv_data_arbiter #(.TIMEOUT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] a_model, b_model;
    int          resp_lat;
    bit          resp_never;
    bit          resp_fixed;
    logic [31:0] resp_value;
    int          resp_cnt;
    int          cyc, busy, bad_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] resp_of(input logic [27:0] addr);
        return {4'h5, addr} ^ 32'h0A5A_0000;
    endfunction

    task automatic push_exp(input bit who, input logic [31:0] data);
        exp_t e;
        e.who  = who;
        e.data = data;
        sb.push_back(e);
        if (who) b_model = data;
        else     a_model = data;
    endtask

    task automatic issue(input bit who, input logic [27:0] addr, input logic [1:0] wn,
                         input logic [1:0] rn, input logic [31:0] wd);
        if (who) begin
            bus_if.b_addr = addr; bus_if.b_write_n = wn; bus_if.b_read_n = rn; bus_if.b_wdata = wd;
        end else begin
            bus_if.a_addr = addr; bus_if.a_write_n = wn; bus_if.a_read_n = rn; bus_if.a_wdata = wd;
        end
    endtask

    task automatic drop(input bit who);
        issue(who, 28'h0, 2'b11, 2'b11, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        a_model = '0;
        b_model = '0;
    endtask

    // Steps negedges until the requester's ready, counting cycles and active-bus cycles.
    task automatic wait_ready(input bit who, input int limit, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        forever begin
            @(negedge clk);
            n++;
            if (who ? bus_if.b_ready : bus_if.a_ready) break;
            if (bus_if.data_write_n != 2'b11 || bus_if.data_read_n != 2'b11) nbusy++;
            if (n >= limit) break;
        end
        check(who ? "b_ready_seen" : "a_ready_seen", who ? bus_if.b_ready : bus_if.a_ready, 1);
    endtask

    // Peripheral: raises data_ready in the resp_lat-th active-bus cycle.
    initial begin
        bus_if.data_ready = 1'b0;
        bus_if.data_in    = '0;
        resp_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (bus_if.data_write_n != 2'b11 || bus_if.data_read_n != 2'b11) begin
                resp_cnt++;
                bus_if.data_ready = !resp_never && (resp_cnt == resp_lat);
                bus_if.data_in    = resp_fixed ? resp_value : resp_of(bus_if.data_addr);
            end else begin
                resp_cnt = 0;
                bus_if.data_ready = 1'b0;
                bus_if.data_in    = 32'hCAFE_F00D;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (bus_if.a_ready || bus_if.b_ready)) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", {30'd0, bus_if.b_ready, bus_if.a_ready}, 0);
            end else begin
                mon_e = sb.pop_front();
                check("ready_who", {30'd0, bus_if.b_ready, bus_if.a_ready}, mon_e.who ? 2 : 1);
                check("ready_rdata", mon_e.who ? bus_if.b_rdata : bus_if.a_rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=no_finish exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        err_clear = 1'b0;
        drop(0);
        drop(1);
        resp_lat = 1; resp_never = 1'b0; resp_fixed = 1'b0; resp_value = '0;
        a_model = '0; b_model = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr", {4'd0, bus_if.data_addr}, 0);
        check("rst_wn", bus_if.data_write_n, 2'b11);
        check("rst_rn", bus_if.data_read_n, 2'b11);
        check("rst_dout", bus_if.data_out, 0);
        check("rst_ready", {bus_if.a_ready, bus_if.b_ready}, 0);
        check("rst_a_rdata", bus_if.a_rdata, 0);
        check("rst_b_rdata", bus_if.b_rdata, 0);
        check("rst_terr", timeout_err, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single 32-bit read with data_ready in the 3rd BUSY cycle
        resp_fixed = 1'b1; resp_value = 32'h1234_5678; resp_lat = 3;
        issue(0, 28'h800_0010, 2'b11, 2'b10, 32'h0);
        push_exp(0, 32'h1234_5678);
        @(negedge clk);
        check("rd_idle_rn", bus_if.data_read_n, 2'b11);
        @(negedge clk);
        check("rd_addr", {4'd0, bus_if.data_addr}, 32'h0800_0010);
        check("rd_rn", bus_if.data_read_n, 2'b10);
        check("rd_wn", bus_if.data_write_n, 2'b11);
        wait_ready(0, 20, cyc, busy);
        check("rd_latency", cyc, 3);
        drop(0);
        @(negedge clk);
        check("rd_pulse", bus_if.a_ready, 0);
        check("rd_a_rdata", bus_if.a_rdata, 32'h1234_5678);
        check("rd_b_rdata", bus_if.b_rdata, 0);
        resp_fixed = 1'b0;

        // Contention after reset, then round-robin
        resp_lat = 1;
        do_reset();
        issue(0, 28'h100, 2'b11, 2'b10, 32'h0);
        issue(1, 28'h200, 2'b11, 2'b10, 32'h0);
        push_exp(0, resp_of(28'h100));
        push_exp(1, resp_of(28'h200));
        @(negedge clk);
        @(negedge clk);
        check("cont_first_addr", {4'd0, bus_if.data_addr}, 32'h100);
        wait_ready(0, 20, cyc, busy);
        drop(0);
        @(negedge clk);
        check("cont_a_pulse", bus_if.a_ready, 0);
        check("cont_idle_rn", bus_if.data_read_n, 2'b11);
        @(negedge clk);
        check("cont_b_addr", {4'd0, bus_if.data_addr}, 32'h200);
        wait_ready(1, 20, cyc, busy);
        drop(1);
        issue(0, 28'h110, 2'b11, 2'b10, 32'h0);
        issue(1, 28'h210, 2'b11, 2'b10, 32'h0);
        push_exp(0, resp_of(28'h110));
        push_exp(1, resp_of(28'h210));
        @(negedge clk);
        @(negedge clk);
        check("cont_rr_addr", {4'd0, bus_if.data_addr}, 32'h110);
        wait_ready(0, 20, cyc, busy);
        drop(0);
        wait_ready(1, 20, cyc, busy);
        drop(1);
        @(negedge clk);

        // B 8-bit write: bus stable for all of BUSY, b_rdata untouched
        resp_lat = 4;
        issue(1, 28'h300, 2'b00, 2'b11, 32'h0000_00AB);
        push_exp(1, b_model);
        bad_cycles = 0; busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.b_ready) break;
            if (bus_if.data_write_n != 2'b11) begin
                busy++;
                if (bus_if.data_write_n !== 2'b00 || bus_if.data_out !== 32'hAB ||
                    bus_if.data_read_n !== 2'b11 || bus_if.data_addr !== 28'h300) bad_cycles++;
            end
        end
        check("wr_ready", bus_if.b_ready, 1);
        check("wr_busy_cycles", busy, 4);
        check("wr_bus_stable", bad_cycles, 0);
        drop(1);
        @(negedge clk);
        check("wr_b_rdata", bus_if.b_rdata, b_model);

        // Write and read both asserted: write wins, read forwarded as 11
        resp_lat = 2;
        issue(0, 28'h310, 2'b10, 2'b10, 32'hDEAD_BEEF);
        push_exp(0, a_model);
        @(negedge clk);
        @(negedge clk);
        check("wr_prec_wn", bus_if.data_write_n, 2'b10);
        check("wr_prec_rn", bus_if.data_read_n, 2'b11);
        check("wr_prec_dout", bus_if.data_out, 32'hDEAD_BEEF);
        wait_ready(0, 20, cyc, busy);
        drop(0);
        @(negedge clk);

        // Timeout: abort after 255 BUSY cycles, sticky error
        resp_never = 1'b1;
        issue(0, 28'h400, 2'b11, 2'b10, 32'h0);
        push_exp(0, 32'hFFFF_FFFF);
        wait_ready(0, 400, cyc, busy);
        check("to_busy_cycles", busy, 255);
        check("to_err_set", timeout_err, 1);
        drop(0);
        repeat (5) @(negedge clk);
        check("to_err_sticky", timeout_err, 1);
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        @(negedge clk);
        check("to_err_clear", timeout_err, 0);

        // data_ready in the expiry cycle completes normally
        resp_never = 1'b0; resp_lat = 255;
        issue(1, 28'h500, 2'b11, 2'b01, 32'h0);
        push_exp(1, resp_of(28'h500));
        wait_ready(1, 400, cyc, busy);
        check("race_busy_cycles", busy, 255);
        check("race_no_err", timeout_err, 0);
        drop(1);
        @(negedge clk);

        // Timeout with err_clear held: set wins, then clears
        resp_never = 1'b1;
        err_clear = 1'b1;
        issue(0, 28'h600, 2'b11, 2'b00, 32'h0);
        push_exp(0, 32'hFFFF_FFFF);
        wait_ready(0, 400, cyc, busy);
        check("to2_set_wins", timeout_err, 1);
        drop(0);
        @(negedge clk);
        check("to2_cleared", timeout_err, 0);
        err_clear = 1'b0;

        // Reset mid-BUSY: no ready pulse, request re-arbitrated afterwards
        @(posedge clk); #1;
        issue(0, 28'h700, 2'b11, 2'b10, 32'h0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        resp_never = 1'b0; resp_lat = 2;
        @(posedge clk); #1 rst = 1'b0;
        a_model = '0; b_model = '0;
        @(negedge clk);
        check("mid_rst_addr", {4'd0, bus_if.data_addr}, 0);
        check("mid_rst_rn", bus_if.data_read_n, 2'b11);
        check("mid_rst_dout", bus_if.data_out, 0);
        check("mid_rst_ready", {bus_if.a_ready, bus_if.b_ready}, 0);
        check("mid_rst_a_rdata", bus_if.a_rdata, 0);
        push_exp(0, resp_of(28'h700));
        wait_ready(0, 20, cyc, busy);
        check("mid_rst_rearb_busy", busy, 2);
        drop(0);
        @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
